// File: rtl/dl11_console.sv
// DL11-style console serial interface: RCSR/RBUF/XCSR/XBUF decoded on the RAM bus,
// with an 8N1 receiver and transmitter and level interrupt requests.
module dl11_console #(
    parameter logic [15:0] BASE_ADDR    = 16'o177560,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic        bytew,
    input  logic [15:0] d_in,
    output logic        sel,
    output logic [15:0] d_out,
    output logic        txd,
    input  logic        rxd,
    output logic        rx_irq,
    output logic        tx_irq
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic       rx_done, rx_ie, rx_err, tx_ready, tx_ie;
    logic [7:0] rx_data;

    logic wr_en, rd_rbuf, tx_load;
    logic rx_complete, tx_finish;

    // Only the low byte carries writable bits.
    logic unused_d_in_hi;
    assign unused_d_in_hi = ^d_in[15:8];

    assign sel     = (addr[15:3] == BASE_ADDR[15:3]);
    assign wr_en   = we && sel && !(bytew && addr[0]);
    assign rd_rbuf = re && sel && (addr[2:1] == 2'd1);
    assign tx_load = wr_en && (addr[2:1] == 2'd3) && tx_ready;

    always_comb begin
        d_out = 16'h0000;
        if (sel) begin
            case (addr[2:1])
                2'd0:    d_out = {8'h00, rx_done, rx_ie, 6'b0};
                2'd1:    d_out = {rx_err, 7'b0, rx_data};
                2'd2:    d_out = {8'h00, tx_ready, tx_ie, 6'b0};
                default: d_out = 16'h0000;
            endcase
        end
    end

    assign rx_irq = rx_done && rx_ie;
    assign tx_irq = tx_ready && tx_ie;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    logic rx_s1, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
        end
    end

    ser_state_t rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_tick;

    assign rx_tick = (rx_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next     = rx_state;
        rx_complete = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_sync) rx_next = S_START;
            S_START: if (rx_tick) rx_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = S_STOP;
            S_STOP: begin
                if (rx_tick) begin
                    rx_next     = S_IDLE;
                    rx_complete = 1'b1;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= CNT_HALF;
            rx_idx   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= CNT_HALF;
                    rx_idx <= 3'd0;
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                        rx_cnt   <= CNT_FULL;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_cnt <= rx_tick ? CNT_FULL : rx_cnt - 16'd1;
            endcase
        end
    end

    ser_state_t tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;
    logic        tx_tick;

    assign tx_tick = (tx_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next   = tx_state;
        tx_finish = 1'b0;
        case (tx_state)
            S_IDLE:  if (tx_load) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = S_STOP;
            S_STOP: begin
                if (tx_tick) begin
                    tx_next   = S_IDLE;
                    tx_finish = 1'b1;
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt   <= CNT_FULL;
            tx_idx   <= 3'd0;
            tx_shift <= 8'h00;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= CNT_FULL;
                    tx_idx <= 3'd0;
                    if (tx_load) tx_shift <= d_in[7:0];
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_idx   <= tx_idx + 3'd1;
                        tx_cnt   <= CNT_FULL;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_cnt <= tx_tick ? CNT_FULL : tx_cnt - 16'd1;
            endcase
        end
    end

    always_comb begin
        case (tx_state)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_shift[0];
            default: txd = 1'b1;
        endcase
    end

    // A completion in the same cycle as an RBUF read overrides the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_done  <= 1'b0;
            rx_ie    <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= 8'h00;
            tx_ready <= 1'b1;
            tx_ie    <= 1'b0;
        end else begin
            if (rd_rbuf) begin
                rx_done <= 1'b0;
                rx_err  <= 1'b0;
            end
            if (rx_complete) begin
                rx_data <= rx_shift;
                rx_done <= 1'b1;
                rx_err  <= !rx_sync || rx_done;
            end
            if (wr_en && addr[2:1] == 2'd0) rx_ie <= d_in[6];
            if (wr_en && addr[2:1] == 2'd2) tx_ie <= d_in[6];
            if (tx_load)        tx_ready <= 1'b0;
            else if (tx_finish) tx_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dl11_console.sv
// Self-checking bench for dl11_console: serial frames are checked bit-cell by
// bit-cell and register reads against a small register-level model.
module tb_dl11_console;

    localparam int          CPB  = 16;
    localparam logic [15:0] RCSR = 16'o177560;
    localparam logic [15:0] RBUF = 16'o177562;
    localparam logic [15:0] XCSR = 16'o177564;
    localparam logic [15:0] XBUF = 16'o177566;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        we = 1'b0, re = 1'b0, bytew = 1'b0;
    logic [15:0] d_in = 16'h0000;
    logic        sel;
    logic [15:0] d_out;
    logic        txd;
    logic        rxd = 1'b1;
    logic        rx_irq, tx_irq;

    int checks = 0;
    int passes = 0;

    // receiver-side model
    bit         exp_done = 0, exp_err = 0, exp_rx_ie = 0;
    logic [7:0] exp_data = 8'h00;

    dl11_console #(.BASE_ADDR(16'o177560), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .bytew(bytew),
        .d_in(d_in), .sel(sel), .d_out(d_out), .txd(txd), .rxd(rxd),
        .rx_irq(rx_irq), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_rcsr();
        return {8'h00, exp_done, exp_rx_ie, 6'b0};
    endfunction

    function automatic logic [15:0] exp_rbuf();
        return {exp_err, 7'b0, exp_data};
    endfunction

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit bw);
        @(negedge clk);
        addr = a; d_in = d; bytew = bw; we = 1'b1;
        @(negedge clk);
        we = 1'b0; bytew = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        @(negedge clk);
        addr = a; re = 1'b0;
        #1 v = d_out;
    endtask

    task automatic rd_clear(output logic [15:0] v);
        @(negedge clk);
        addr = RBUF; re = 1'b1;
        #1 v = d_out;
        @(negedge clk);
        re = 1'b0;
        exp_done = 0; exp_err = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        exp_err  = !stop_bit || exp_done;
        exp_done = 1;
        exp_data = b;
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit inject);
        logic [9:0]  frame;
        int          bad_bit, bad_rdy;
        logic [15:0] v;
        frame = {1'b1, b, 1'b0};
        bad_rdy = 0;
        @(negedge clk);
        addr = XBUF; d_in = {8'hA5, b}; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr = XCSR;
        for (int bit_i = 0; bit_i < 10; bit_i++) begin
            bad_bit = 0;
            for (int c = 0; c < CPB; c++) begin
                if (inject && bit_i == 3 && c == 5) begin
                    addr = XBUF; d_in = 16'h0055; we = 1'b1;
                end else begin
                    we = 1'b0; addr = XCSR;
                end
                #1;
                if (txd !== frame[bit_i]) bad_bit++;
                if (addr == XCSR && d_out !== 16'h0000) bad_rdy++;
                @(negedge clk);
            end
            checks++;
            if (bad_bit !== 0)
                $display("FAIL tx_bit byte=%h bit=%0d: %0d of %0d cycles wrong, expected txd=%b",
                         b, bit_i, bad_bit, CPB, frame[bit_i]);
            else passes++;
        end
        checks++;
        if (bad_rdy !== 0)
            $display("FAIL tx_busy_xcsr byte=%h: XCSR nonzero in %0d frame cycles, expected 0", b, bad_rdy);
        else passes++;
        #1 v = d_out;
        checks++;
        if (v !== 16'o000200)
            $display("FAIL tx_ready_at_end byte=%h: XCSR=%o expected 000200", b, v);
        else passes++;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd(XCSR, v);
        checks++;
        if (v !== 16'o000200) $display("FAIL reset_xcsr: got %o expected 000200", v); else passes++;
        rd(RCSR, v);
        checks++;
        if (v !== 16'o000000) $display("FAIL reset_rcsr: got %o expected 000000", v); else passes++;
        rd(RBUF, v);
        checks++;
        if (v !== 16'h0000) $display("FAIL reset_rbuf: got %h expected 0000", v); else passes++;
        checks++;
        if ({txd, rx_irq, tx_irq} !== 3'b100)
            $display("FAIL reset_lines: txd/rx_irq/tx_irq=%b expected 100", {txd, rx_irq, tx_irq});
        else passes++;
        rd(16'o177570, v);
        checks++;
        if ({sel, v} !== 17'h0) $display("FAIL decode_miss: sel=%b d_out=%h expected 0/0", sel, v); else passes++;
        rd(XBUF, v);
        checks++;
        if ({sel, v} !== {1'b1, 16'h0}) $display("FAIL decode_xbuf: sel=%b d_out=%h expected 1/0", sel, v); else passes++;
    endtask

    task automatic test_tx();
        tx_frame(8'h41, 1'b0);
        for (int i = 0; i < 2; i++) tx_frame(8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic test_tx_busy();
        int bad;
        tx_frame(8'($urandom_range(0, 255)), 1'b1);
        bad = 0;
        addr = XCSR;
        for (int c = 0; c < 12 * CPB; c++) begin
            #1;
            if (txd !== 1'b1 || d_out !== 16'o000200) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) $display("FAIL tx_no_second_frame: %0d idle cycles wrong, expected 0", bad);
        else passes++;
    endtask

    task automatic test_rx();
        logic [15:0] v;
        logic [7:0]  b;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            send_rx(b, 1'b1);
            rd(RCSR, v);
            checks++;
            if (v !== exp_rcsr()) $display("FAIL rx_done byte=%h: RCSR=%o expected %o", b, v, exp_rcsr());
            else passes++;
            rd_clear(v);
            checks++;
            if (v !== {1'b0, 7'b0, b}) $display("FAIL rx_rbuf byte=%h: got %h expected %h", b, v, {8'h00, b});
            else passes++;
            rd(RCSR, v);
            checks++;
            if (v !== exp_rcsr()) $display("FAIL rx_clear byte=%h: RCSR=%o expected %o", b, v, exp_rcsr());
            else passes++;
        end
    endtask

    task automatic test_overrun();
        logic [15:0] v;
        logic [7:0]  b1, b2;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        send_rx(b1, 1'b1);
        send_rx(b2, 1'b1);
        rd_clear(v);
        checks++;
        if (v !== {8'h80, b2}) $display("FAIL rx_overrun: RBUF=%h expected %h", v, {8'h80, b2});
        else passes++;
        rd(RBUF, v);
        checks++;
        if (v !== exp_rbuf()) $display("FAIL rx_err_clear: RBUF=%h expected %h", v, exp_rbuf());
        else passes++;
    endtask

    task automatic test_framing();
        logic [15:0] v;
        logic [7:0]  b;
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b0);
        rd(RCSR, v);
        checks++;
        if (v !== exp_rcsr()) $display("FAIL rx_frame_done: RCSR=%o expected %o", v, exp_rcsr());
        else passes++;
        rd_clear(v);
        checks++;
        if (v !== {8'h80, b}) $display("FAIL rx_framing_err: RBUF=%h expected %h", v, {8'h80, b});
        else passes++;
    endtask

    task automatic test_glitch();
        logic [15:0] v;
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        rd(RCSR, v);
        checks++;
        if (v !== 16'o000000) $display("FAIL rx_glitch: RCSR=%o expected 000000", v); else passes++;
    endtask

    task automatic test_ie();
        logic [15:0] v;
        wr(XCSR, 16'o000100, 1'b0);
        #1;
        checks++;
        if (tx_irq !== 1'b1) $display("FAIL tx_irq_set: got %b expected 1", tx_irq); else passes++;
        wr(XCSR + 16'd1, 16'h0000, 1'b1);
        rd(XCSR, v);
        checks++;
        if (v !== 16'o000300) $display("FAIL odd_byte_ignored: XCSR=%o expected 000300", v); else passes++;
        wr(XCSR, 16'o000000, 1'b1);
        rd(XCSR, v);
        checks++;
        if ({tx_irq, v} !== {1'b0, 16'o000200})
            $display("FAIL tx_ie_clear: tx_irq=%b XCSR=%o expected 0/000200", tx_irq, v);
        else passes++;
        wr(RCSR, 16'o000300, 1'b0);
        exp_rx_ie = 1;
        rd(RCSR, v);
        checks++;
        if ({rx_irq, v} !== {1'b0, exp_rcsr()})
            $display("FAIL rcsr_ro_done: rx_irq=%b RCSR=%o expected 0/%o", rx_irq, v, exp_rcsr());
        else passes++;
        send_rx(8'($urandom_range(0, 255)), 1'b1);
        #1;
        checks++;
        if (rx_irq !== (exp_done && exp_rx_ie)) $display("FAIL rx_irq_set: got %b expected 1", rx_irq);
        else passes++;
        rd_clear(v);
        #1;
        checks++;
        if (rx_irq !== 1'b0) $display("FAIL rx_irq_clear: got %b expected 0", rx_irq); else passes++;
        wr(RCSR, 16'o000000, 1'b0);
        exp_rx_ie = 0;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v;
        wr(XCSR, 16'o000100, 1'b0);
        wr(XBUF, {8'h00, 8'($urandom_range(0, 255))}, 1'b0);
        repeat (50) @(negedge clk);
        rd(XCSR, v);
        checks++;
        if (v !== 16'o000100) $display("FAIL tx_busy_before_reset: XCSR=%o expected 000100", v); else passes++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        addr = XCSR;
        #1;
        checks++;
        if ({txd, tx_irq, d_out} !== {1'b1, 1'b0, 16'o000200})
            $display("FAIL reset_mid_frame: txd=%b tx_irq=%b XCSR=%o expected 1/0/000200", txd, tx_irq, d_out);
        else passes++;
        reset = 1'b0;
        exp_done = 0; exp_err = 0; exp_rx_ie = 0; exp_data = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_busy();
        test_rx();
        test_overrun();
        test_framing();
        test_glitch();
        test_ie();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
